// File: rtl/hw_imp_pkg.sv
// hw_imp_pkg: shared state encoding and slave register map for the hw_imp host.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hw_imp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_POLL  = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    localparam logic ADDR_STATUS     = 1'b0;
    localparam logic ADDR_DATA       = 1'b1;
    localparam int   STATUS_DONE_BIT = 0;

endpackage

// File: rtl/hw_imp_host_fifo.sv
// hw_imp_host_fifo: synchronous word buffer with flush, head exposed combinationally.
// Latency: a pushed word is visible at head the cycle after the push.
// Backpressure: caller must not push when full nor pop when empty; flush empties in one cycle.
module hw_imp_host_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (count == CNT_W'(DEPTH));
    assign head  = mem[rd_ptr[PTR_W-1:0]];

    // Storage array needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

    // Pointer update; flush discards everything in a single cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + CNT_W'(1);
            if (pop)  rd_ptr <= rd_ptr + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hw_imp_host.sv
// hw_imp_host: Avalon-MM initiator; writes buffered words to hw_imp, polls done, reads result.
// Latency: first strobe 1 cycle after start; zero-wait slave, N words, done set -> result_valid at start+N+3.
// Backpressure: in_ready low when full or busy; avm_waitrequest holds address/data/strobe stable.
// Optional build macro HW_IMP_HOST_TIMEOUT_EN: per-phase cycle budget, abort with error pulse.
module hw_imp_host #(
    parameter int   DATA_W         = 32,
    parameter int   FIFO_DEPTH     = 16,
    parameter logic ADDR_STATUS    = hw_imp_pkg::ADDR_STATUS,
    parameter logic ADDR_DATA      = hw_imp_pkg::ADDR_DATA,
    parameter int   TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              start,
    output logic              busy,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              error,
    output logic              avm_address,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    output logic              avm_read,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);
    import hw_imp_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("hw_imp_host: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
    end

    state_t            state;
    logic              run;
    logic              poll_gap;
    logic              push;
    logic              pop;
    logic              flush;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              wr_done;
    logic              rd_done;
    logic              tmo_expire;

    // run keeps in_ready low while reset is asserted and rises on the first cycle after release.
    assign in_ready      = run && !fifo_full && (state == ST_IDLE);
    assign push          = in_valid && in_ready;
    assign wr_done       = avm_write && !avm_waitrequest;
    assign rd_done       = avm_read && !avm_waitrequest;
    assign pop           = (state == ST_WRITE) && wr_done;
    assign flush         = tmo_expire;
    assign busy          = (state != ST_IDLE);
    // Head only changes on a completed write, so data is stable across waitrequest.
    assign avm_writedata = avm_write ? fifo_head : '0;

    hw_imp_host_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

`ifdef HW_IMP_HOST_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             error_q;

    // A completion on the last budget cycle still counts; only a stalled or idle-gap cycle expires.
    assign tmo_expire = busy && (tmo_cnt == '0) && !wr_done && !rd_done;
    assign error      = error_q;

    // Budget reloads in IDLE and on every completion, which covers every phase entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= TMO_LOAD;
            error_q <= 1'b0;
        end else begin
            error_q <= tmo_expire;
            if (!busy || wr_done || rd_done || tmo_expire) begin
                tmo_cnt <= TMO_LOAD;
            end else begin
                tmo_cnt <= tmo_cnt - TMO_W'(1);
            end
        end
    end
`else
    assign tmo_expire = 1'b0;
    assign error      = 1'b0;
`endif

    // Transaction sequencer: strobes and address are registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            run          <= 1'b0;
            poll_gap     <= 1'b0;
            avm_address  <= 1'b0;
            avm_write    <= 1'b0;
            avm_read     <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            run          <= 1'b1;
            result_valid <= 1'b0;
            if (tmo_expire) begin
                state     <= ST_IDLE;
                poll_gap  <= 1'b0;
                avm_write <= 1'b0;
                avm_read  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // A word pushed in the start cycle is already at head next cycle.
                        if (start) begin
                            if (!fifo_empty || push) begin
                                state       <= ST_WRITE;
                                avm_write   <= 1'b1;
                                avm_address <= ADDR_DATA;
                            end else begin
                                state       <= ST_POLL;
                                avm_read    <= 1'b1;
                                avm_address <= ADDR_STATUS;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (wr_done && fifo_count == CNT_W'(1)) begin
                            state       <= ST_POLL;
                            avm_write   <= 1'b0;
                            avm_read    <= 1'b1;
                            avm_address <= ADDR_STATUS;
                        end
                    end
                    ST_POLL: begin
                        if (poll_gap) begin
                            poll_gap <= 1'b0;
                            avm_read <= 1'b1;
                        end else if (rd_done) begin
                            if (avm_readdata[STATUS_DONE_BIT]) begin
                                state       <= ST_READ;
                                avm_address <= ADDR_DATA;
                            end else begin
                                avm_read <= 1'b0;
                                poll_gap <= 1'b1;
                            end
                        end
                    end
                    ST_READ: begin
                        if (rd_done) begin
                            result       <= avm_readdata;
                            result_valid <= 1'b1;
                            avm_read     <= 1'b0;
                            state        <= ST_IDLE;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        avm_write <= 1'b0;
                        avm_read  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hw_imp_host.sv
// tb_hw_imp_host: table-driven and randomized transactions against a behavioural Avalon slave.
// Latency: expected latency per transaction from words, stalls and not-done polls.
// Backpressure: slave inserts waitrequest stalls and not-done status replies.
module tb_hw_imp_host;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          start = 1'b0;
    logic          busy;
    logic [DW-1:0] result;
    logic          result_valid;
    logic          error;
    logic          avm_address;
    logic          avm_write;
    logic [DW-1:0] avm_writedata;
    logic          avm_read;
    logic [DW-1:0] avm_readdata = '0;
    logic          avm_waitrequest = 1'b0;

    hw_imp_host #(
        .DATA_W         (DW),
        .FIFO_DEPTH     (DEPTH),
        .ADDR_STATUS    (1'b0),
        .ADDR_DATA      (1'b1),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .start           (start),
        .busy            (busy),
        .result          (result),
        .result_valid    (result_valid),
        .error           (error),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural slave ----------------
    int   cyc = 0;
    int   cfg_zpolls = 0;
    int   cfg_sidx = -1;
    int   stall_left = 0;
    bit   cfg_stuck = 1'b0;
    logic [DW-1:0] cfg_res = '0;
    int   wr_count = 0;
    int   st_count = 0;
    bit   prev_wait = 1'b0;
    logic [34:0] hold_val = '0;
    logic    wlog_addr[$];
    logic [DW-1:0] wlog_data[$];
    int      wlog_cyc[$];
    int      plog_cyc[$];
    int      rlog_cyc[$];
    bit      err_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (error === 1'b1 && !cfg_stuck) err_seen <= 1'b1;

    // Slave decides waitrequest/readdata mid-cycle; a transfer with wait low completes at the next edge.
    always @(negedge clk) begin
        logic          wait_now;
        logic [DW-1:0] rd;
        if (!reset_n) begin
            avm_waitrequest = 1'b0;
            prev_wait = 1'b0;
        end else begin
            if (prev_wait && !cfg_stuck)
                chk("hold", 64'({avm_write, avm_read, avm_address, avm_writedata}), 64'(hold_val));
            if (avm_write || avm_read)
                chk("rw_exclusive", 64'(avm_write & avm_read), 64'(0));
            wait_now = 1'b0;
            if (cfg_stuck && (avm_write || avm_read)) begin
                wait_now = 1'b1;
            end else if (avm_write && wr_count == cfg_sidx && stall_left > 0) begin
                wait_now = 1'b1;
                stall_left--;
            end
            rd = $urandom();
            if (avm_read && avm_address == 1'b0) rd[0] = (st_count >= cfg_zpolls);
            else if (avm_read) rd = cfg_res;
            avm_readdata = rd;
            avm_waitrequest = wait_now;
            if (!wait_now) begin
                if (avm_write) begin
                    wlog_addr.push_back(avm_address);
                    wlog_data.push_back(avm_writedata);
                    wlog_cyc.push_back(cyc);
                    wr_count++;
                end
                if (avm_read && avm_address == 1'b0) begin
                    plog_cyc.push_back(cyc);
                    st_count++;
                end else if (avm_read) begin
                    rlog_cyc.push_back(cyc);
                end
            end
            prev_wait = wait_now && (avm_write || avm_read);
            hold_val = {avm_write, avm_read, avm_address, avm_writedata};
        end
    end

    // ---------------- transaction vectors ----------------
    typedef struct {
        int            n;
        int            z;
        int            sidx;
        int            scyc;
        bit            same;
        bit            poke;
        logic [DW-1:0] res;
        logic [DW-1:0] w0, w1, w2, w3;
        int            lat;
    } vec_t;

    function automatic vec_t mk(input int n, input int z, input int sidx, input int scyc,
                                input bit same, input bit poke, input logic [DW-1:0] res,
                                input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                input logic [DW-1:0] w2, input logic [DW-1:0] w3, input int lat);
        vec_t v;
        v.n = n; v.z = z; v.sidx = sidx; v.scyc = scyc; v.same = same; v.poke = poke;
        v.res = res; v.w0 = w0; v.w1 = w1; v.w2 = w2; v.w3 = w3; v.lat = lat;
        return v;
    endfunction

    function automatic logic [DW-1:0] word_of(input vec_t v, input int i);
        case (i)
            0: return v.w0;
            1: return v.w1;
            2: return v.w2;
            3: return v.w3;
            default: return $urandom();
        endcase
    endfunction

    task automatic run_txn(input vec_t v);
        logic [DW-1:0] exp_w[$];
        logic [DW-1:0] w;
        int k;
        int start_cyc;
        int npush;
        int exp_c;
        cfg_zpolls = v.z; cfg_sidx = v.sidx; stall_left = v.scyc; cfg_res = v.res;
        wr_count = 0; st_count = 0; err_seen = 1'b0;
        wlog_addr.delete(); wlog_data.delete(); wlog_cyc.delete();
        plog_cyc.delete(); rlog_cyc.delete();
        npush = (v.same && v.n > 0) ? v.n - 1 : v.n;
        for (int i = 0; i < npush; i++) begin
            w = word_of(v, i);
            exp_w.push_back(w);
            in_valid = 1'b1; in_data = w;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("in_ready_level", 64'(in_ready), 64'((npush == DEPTH) ? 0 : 1));
        if (v.same && v.n > 0) begin
            w = word_of(v, v.n - 1);
            exp_w.push_back(w);
            in_valid = 1'b1; in_data = w;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        start_cyc = cyc;
        k = 1;
        chk("busy_after_start", 64'(busy), 64'(1));
        chk("first_strobe", 64'({avm_write, avm_read, avm_address}), 64'((v.n > 0) ? 3'b101 : 3'b010));
        while (result_valid !== 1'b1 && k < 300) begin
            if (v.poke && k == 2) begin
                start = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_0000;
                chk("in_ready_busy", 64'(in_ready), 64'(0));
            end
            @(posedge clk); #1;
            start = 1'b0; in_valid = 1'b0;
            k++;
        end
        chk("latency", 64'(k), 64'(v.lat));
        chk("result", 64'(result), 64'(v.res));
        chk("busy_end", 64'(busy), 64'(0));
        @(posedge clk); #1;
        chk("rv_pulse", 64'(result_valid), 64'(0));
        chk("result_hold", 64'(result), 64'(v.res));
        chk("write_count", 64'(wlog_data.size()), 64'(v.n));
        for (int i = 0; i < v.n && i < wlog_data.size(); i++) begin
            exp_c = i + 1 + ((v.sidx >= 0 && i >= v.sidx) ? v.scyc : 0);
            chk("write_addr", 64'(wlog_addr[i]), 64'(1));
            chk("write_data", 64'(wlog_data[i]), 64'(exp_w[i]));
            chk("write_cycle", 64'(wlog_cyc[i] - start_cyc + 1), 64'(exp_c));
        end
        chk("poll_count", 64'(plog_cyc.size()), 64'(v.z + 1));
        for (int i = 1; i < plog_cyc.size(); i++)
            chk("poll_gap", 64'(plog_cyc[i] - plog_cyc[i-1]), 64'(2));
        chk("read_count", 64'(rlog_cyc.size()), 64'(1));
        if (rlog_cyc.size() == 1 && plog_cyc.size() > 0)
            chk("read_after_poll", 64'(rlog_cyc[0] - plog_cyc[plog_cyc.size()-1]), 64'(1));
        chk("no_error", 64'(err_seen), 64'(0));
    endtask

    vec_t tbl[7];

    initial begin
        vec_t v;
        int k;
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t v;
        int k;
        // Expected latency = words + stall cycles + 2 per not-done poll + 3.
        tbl[0] = mk(4,  0, -1, 0, 0, 0, 32'h89ABCDEF, 32'd1, 32'd2, 32'd3, 32'd4, 7);
        tbl[1] = mk(4,  0,  1, 3, 0, 0, 32'h5A5A0001, 32'h11110000, 32'h01234567, 32'h22220000, 32'h33330000, 10);
        tbl[2] = mk(2,  2, -1, 0, 0, 0, 32'hC0FFEE00, 32'hAAAA0001, 32'hAAAA0002, 0, 0, 9);
        tbl[3] = mk(0,  0, -1, 0, 0, 1, 32'h0000BEEF, 0, 0, 0, 0, 3);
        tbl[4] = mk(1,  1, -1, 0, 1, 0, 32'h12345678, 32'hA5A5A5A5, 0, 0, 0, 6);
        tbl[5] = mk(16, 0, -1, 0, 0, 1, 32'hFFFFFFFF, 32'h10, 32'h20, 32'h30, 32'h40, 19);
        tbl[6] = mk(3,  1,  0, 2, 1, 0, 32'h00C0FFEE, 32'h7, 32'h8, 32'h9, 0, 10);

        // Reset: outputs low and in_ready low while reset is held for two cycles.
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("rst_in_ready", 64'(in_ready), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_strobes", 64'({avm_write, avm_read, avm_address}), 64'(0));
            chk("rst_flags", 64'({result_valid, error}), 64'(0));
            chk("rst_data", 64'({result, avm_writedata}), 64'(0));
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", 64'(in_ready), 64'(1));

        foreach (tbl[i]) run_txn(tbl[i]);

        // Reset mid-transfer drops strobes immediately and empties the buffer.
        v = mk(3, 0, -1, 0, 0, 0, 32'h1, 32'h5, 32'h6, 32'h7, 0, 6);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = word_of(v, i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_write", 64'(avm_write), 64'(1));
        reset_n = 1'b0;
        #1;
        chk("async_reset_strobes", 64'({avm_write, avm_read}), 64'(0));
        chk("async_reset_busy", 64'(busy), 64'(0));
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_mid_reset", 64'(in_ready), 64'(1));
        run_txn(mk(0, 1, -1, 0, 0, 0, 32'h0BADF00D, 0, 0, 0, 0, 5));

`ifdef HW_IMP_HOST_TIMEOUT_EN
        // Stuck slave: strobe held for the 8-cycle budget, error pulse the cycle after, buffer flushed.
        cfg_stuck = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 32'hE0 + i;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (k = 1; k <= 8; k++) begin
            chk("tmo_strobe", 64'({avm_write, error}), 64'(2'b10));
            @(posedge clk); #1;
        end
        chk("tmo_error", 64'(error), 64'(1));
        chk("tmo_strobes_low", 64'({avm_write, avm_read}), 64'(0));
        chk("tmo_busy", 64'(busy), 64'(0));
        chk("tmo_result_kept", 64'(result), 64'(32'h0BADF00D));
        @(posedge clk); #1;
        chk("tmo_error_pulse", 64'(error), 64'(0));
        cfg_stuck = 1'b0;
        run_txn(mk(0, 0, -1, 0, 0, 0, 32'h600D600D, 0, 0, 0, 0, 3));
`endif

        // Randomized transactions against the latency/ordering model.
        for (int r = 0; r < 20; r++) begin
            v.n    = $urandom_range(0, DEPTH);
            v.z    = $urandom_range(0, 3);
            v.scyc = (v.n > 0) ? $urandom_range(0, 4) : 0;
            v.sidx = (v.scyc > 0) ? $urandom_range(0, v.n - 1) : -1;
            v.same = 1'($urandom_range(0, 1));
            v.poke = 1'($urandom_range(0, 1));
            v.res  = $urandom();
            v.w0 = $urandom(); v.w1 = $urandom(); v.w2 = $urandom(); v.w3 = $urandom();
            v.lat  = v.n + v.scyc + 2 * v.z + 3;
            run_txn(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
